// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state and memory-port owner.
package dmem_arb_pkg;

  typedef enum logic {S_CPU, S_DBG} arb_state_t;
  typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

  function automatic owner_t port_owner(input logic dbg_gnt);
    return dbg_gnt ? OWN_DBG : OWN_CPU;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, debug and data_memory signals of the arbiter; slave = arbiter view, master = environment view.
interface dmem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     cpu_req_i, cpu_we_i;
  logic [ADDRESS_WIDTH-1:0] cpu_addr_i;
  logic [DATA_WIDTH-1:0]    cpu_wdata_i, cpu_rdata_o;
  logic                     cpu_stall_o;
  logic                     dbg_req_i, dbg_we_i, dbg_lock_i;
  logic [ADDRESS_WIDTH-1:0] dbg_addr_i;
  logic [DATA_WIDTH-1:0]    dbg_wdata_i, dbg_rdata_o;
  logic                     dbg_gnt_o, dbg_rvalid_o;
  logic                     mem_we_o;
  logic [ADDRESS_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0]    mem_wdata_o, mem_rdata_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  dbg_req_i, dbg_we_i, dbg_lock_i, dbg_addr_i, dbg_wdata_i,
    input  mem_rdata_i,
    output cpu_rdata_o, cpu_stall_o, dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    output mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output dbg_req_i, dbg_we_i, dbg_lock_i, dbg_addr_i, dbg_wdata_i,
    output mem_rdata_i,
    input  cpu_rdata_o, cpu_stall_o, dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    input  mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dmem_starve_cnt.sv
// Saturating count of consecutive refused debug cycles (DMEM_ARB_STARVE_EN builds only).
`ifdef DMEM_ARB_STARVE_EN
module dmem_starve_cnt #(
  parameter int LIMIT = 4,
  parameter int W     = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req,
  input  logic gnt,
  output logic hit
);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || !req || gnt) cnt <= '0;
    else if (cnt != LIM)      cnt <= cnt + 1'b1;
  end

  assign hit = (cnt == LIM);
endmodule
`endif

// File: rtl/dmem_arbiter.sv
// Shares data_memory between the CPU load/store path and a debug port; CPU wins by default.
// DMEM_ARB_STARVE_EN adds a forced debug grant after STARVE_LIMIT refused cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH    = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int STARVE_LIMIT     = 4,
  parameter int STARVE_CNT_WIDTH = 4
) (
  input logic         clk_i,
  input logic         rst_i,
  dmem_arbiter_if.slave bus
);
  arb_state_t               state;
  owner_t                   owner;
  logic                     starve_hit, dbg_gnt, dbg_rd;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;

  // While locked the debug side owns the port for every cycle it keeps requesting.
  assign dbg_gnt = !rst_i && bus.dbg_req_i &&
                   (state == S_DBG || !bus.cpu_req_i || starve_hit);
  assign dbg_rd  = dbg_gnt && !bus.dbg_we_i;
  assign owner   = port_owner(dbg_gnt);

  assign mem_addr  = (owner == OWN_DBG) ? bus.dbg_addr_i  : bus.cpu_addr_i;
  assign mem_wdata = (owner == OWN_DBG) ? bus.dbg_wdata_i : bus.cpu_wdata_i;

  assign bus.dbg_gnt_o   = dbg_gnt;
  assign bus.cpu_stall_o = !rst_i && bus.cpu_req_i && (dbg_gnt || state == S_DBG);
  assign bus.mem_we_o    = !rst_i && ((owner == OWN_DBG) ? bus.dbg_we_i
                                                         : (bus.cpu_req_i && bus.cpu_we_i));
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_wdata_o = mem_wdata;
  assign bus.cpu_rdata_o = bus.mem_rdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= S_CPU;
      bus.dbg_rvalid_o <= 1'b0;
      bus.dbg_rdata_o  <= '0;
    end else begin
      unique case (state)
        S_CPU: if (dbg_gnt && bus.dbg_lock_i) state <= S_DBG;
        S_DBG: if (!bus.dbg_req_i || !bus.dbg_lock_i) state <= S_CPU;
        default: state <= S_CPU;
      endcase
      bus.dbg_rvalid_o <= dbg_rd;
      if (dbg_rd) bus.dbg_rdata_o <= bus.mem_rdata_i;
    end
  end

`ifdef DMEM_ARB_STARVE_EN
  dmem_starve_cnt #(
    .LIMIT (STARVE_LIMIT),
    .W     (STARVE_CNT_WIDTH)
  ) u_starve (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req   (bus.dbg_req_i),
    .gnt   (dbg_gnt),
    .hit   (starve_hit)
  );
`else
  logic unused_starve_cfg;
  assign starve_hit        = 1'b0;
  assign unused_starve_cfg = ^{STARVE_LIMIT, STARVE_CNT_WIDTH};
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: the driver pushes model predictions, a negedge monitor compares.
module tb_dmem_arbiter;
  localparam int LIMIT = 4;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  dmem_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

  dmem_arbiter #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIMIT), .STARVE_CNT_WIDTH(4)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_if.slave)
  );

  // data_memory: combinational read, write on the rising edge
  logic [31:0] mem [64] = '{default: 32'h0};
  always_comb bus_if.mem_rdata_i = mem[bus_if.mem_addr_o[7:2]];
  always @(posedge clk_i) if (bus_if.mem_we_o) mem[bus_if.mem_addr_o[7:2]] <= bus_if.mem_wdata_o;

  typedef struct {
    bit rst, creq, cwe; logic [31:0] caddr, cwd;
    bit dreq, dwe, dlock; logic [31:0] daddr, dwd;
  } stim_t;

  typedef struct {
    bit chk_bus, chk_reg;
    logic gnt, stall, we, rvalid;
    logic [31:0] addr, wdata, cpu_rd, drdata;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0, n_bad = 0;

  // Reference model: ownership and memory contents tracked at transaction level
  logic [31:0] ref_mem [64] = '{default: 32'h0};
  bit          m_locked = 0, m_reg_known = 0, m_rvalid = 0;
  int          m_refused = 0;
  logic [31:0] m_rdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(bit rst, bit creq, bit cwe, logic [31:0] caddr, logic [31:0] cwd,
                               bit dreq, bit dwe, bit dlock, logic [31:0] daddr, logic [31:0] dwd);
    stim_t s;
    s.rst = rst; s.creq = creq; s.cwe = cwe; s.caddr = caddr; s.cwd = cwd;
    s.dreq = dreq; s.dwe = dwe; s.dlock = dlock; s.daddr = daddr; s.dwd = dwd;
    return s;
  endfunction

  task automatic drive(input stim_t s, output bit g);
    exp_t e;
    @(posedge clk_i); #1;
    rst_i              = s.rst;
    bus_if.cpu_req_i   = s.creq;  bus_if.cpu_we_i    = s.cwe;
    bus_if.cpu_addr_i  = s.caddr; bus_if.cpu_wdata_i = s.cwd;
    bus_if.dbg_req_i   = s.dreq;  bus_if.dbg_we_i    = s.dwe;  bus_if.dbg_lock_i = s.dlock;
    bus_if.dbg_addr_i  = s.daddr; bus_if.dbg_wdata_i = s.dwd;

    e.chk_reg = m_reg_known; e.rvalid = m_rvalid; e.drdata = m_rdata;
    if (s.rst) begin
      g = 0;
      e.chk_bus = 0; e.chk_reg = 0; e.gnt = 0; e.stall = 0; e.we = 0;
      e.addr = 'x; e.wdata = 'x; e.cpu_rd = 'x;
      exp_q.push_back(e);
      m_locked = 0; m_refused = 0; m_rvalid = 0; m_rdata = 32'h0; m_reg_known = 1;
    end else begin
      // Debug wins if it owns the port, the CPU is idle, or it has waited LIMIT cycles.
      g = s.dreq && (m_locked || !s.creq || (STARVE && m_refused == LIMIT));
      e.chk_bus = 1; e.gnt = g;
      e.stall   = s.creq && (g || m_locked);
      e.addr    = g ? s.daddr : s.caddr;
      e.wdata   = g ? s.dwd   : s.cwd;
      e.we      = g ? s.dwe   : (s.creq && s.cwe);
      e.cpu_rd  = ref_mem[e.addr[7:2]];
      exp_q.push_back(e);
      if (e.we) ref_mem[e.addr[7:2]] = e.wdata;
      m_rvalid = g && !s.dwe;
      if (m_rvalid) m_rdata = e.cpu_rd;
      m_locked = g ? s.dlock : (m_locked && s.dreq);
      if (!s.dreq || g) m_refused = 0;
      else if (m_refused < LIMIT) m_refused++;
    end
  endtask

  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("dbg_gnt",   {31'h0, bus_if.dbg_gnt_o},   {31'h0, e.gnt});
      chk("cpu_stall", {31'h0, bus_if.cpu_stall_o}, {31'h0, e.stall});
      chk("mem_we",    {31'h0, bus_if.mem_we_o},    {31'h0, e.we});
      if (e.chk_bus) begin
        chk("mem_addr",  bus_if.mem_addr_o,  e.addr);
        chk("mem_wdata", bus_if.mem_wdata_o, e.wdata);
        chk("cpu_rdata", bus_if.cpu_rdata_o, e.cpu_rd);
      end
      if (e.chk_reg) begin
        chk("dbg_rvalid", {31'h0, bus_if.dbg_rvalid_o}, {31'h0, e.rvalid});
        chk("dbg_rdata",  bus_if.dbg_rdata_o, e.drdata);
      end
    end
  end

  initial begin
    bit g, pend;
    int first_gnt;
    stim_t s;
    rst_i = 1'b1;
    bus_if.cpu_req_i = 0; bus_if.cpu_we_i = 0; bus_if.cpu_addr_i = 0; bus_if.cpu_wdata_i = 0;
    bus_if.dbg_req_i = 0; bus_if.dbg_we_i = 0; bus_if.dbg_lock_i = 0;
    bus_if.dbg_addr_i = 0; bus_if.dbg_wdata_i = 0;

    // Reset with both sides requesting
    repeat (2) drive(mk(1, 1, 1, 32'h4, 32'h11, 1, 1, 0, 32'h8, 32'h22), g);

    // Debug write then read on an idle CPU
    drive(mk(0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h10, 32'hDEADBEEF), g);
    drive(mk(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h10, 32'h0), g);
    drive(mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0), g);
    chk("dbg_rd_0x10", bus_if.dbg_rdata_o, 32'hDEADBEEF);

    // Continuous CPU traffic against a held debug request
    first_gnt = -1;
    for (int i = 0; i < 20; i++) begin
      drive(mk(0, 1, 0, 32'h40, 32'h0, first_gnt < 0, 0, 0, 32'h44, 32'h0), g);
      #1;
      if (bus_if.dbg_gnt_o && first_gnt < 0) first_gnt = i;
    end
    chk("starve_first_gnt", first_gnt, STARVE ? LIMIT : -1);
    drive(mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0), g);

    // Locked read-modify-write at 0x20, CPU busy for the write
    drive(mk(0, 0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h20, 32'h0), g);
    drive(mk(0, 1, 0, 32'h24, 32'h0, 1, 1, 0, 32'h20, 32'h5A5A), g);
    drive(mk(0, 1, 0, 32'h24, 32'h0, 0, 0, 0, 32'h0, 32'h0), g);
    #1 chk("rmw_unstall", {31'h0, bus_if.cpu_stall_o}, 32'h0);

    // Reset taken while locked; the pending debug write must not land
    drive(mk(0, 0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h50, 32'h0), g);
    drive(mk(1, 1, 0, 32'h54, 32'h0, 1, 1, 1, 32'h50, 32'hBAD), g);
    drive(mk(0, 1, 0, 32'h54, 32'h0, 0, 0, 0, 32'h0, 32'h0), g);
    chk("rst_no_write", mem[5'h14], 32'h0);

    // Same-cycle CPU and debug writes to 0x30
    drive(mk(0, 1, 1, 32'h30, 32'h1, 1, 1, 0, 32'h30, 32'h2), g);
    drive(mk(0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h30, 32'h2), g);
    chk("cpu_first_0x30", mem[12], 32'h1);
    drive(mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0), g);
    chk("dbg_later_0x30", mem[12], 32'h2);

    // Randomized traffic; debug requests are held until granted
    pend = 0;
    s = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      s.rst   = ($urandom_range(99) == 0);
      s.creq  = ($urandom_range(9) < 7);
      s.cwe   = $urandom_range(1);
      s.caddr = {24'h0, 6'($urandom_range(63)), 2'b00};
      s.cwd   = $urandom;
      if (!pend && $urandom_range(2) == 0) begin
        pend    = 1;
        s.dwe   = $urandom_range(1);
        s.dlock = ($urandom_range(3) == 0);
        s.daddr = {24'h0, 6'($urandom_range(63)), 2'b00};
        s.dwd   = $urandom;
      end
      s.dreq = pend;
      drive(s, g);
      if (g || s.rst) pend = 0;
    end

    drive(mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0), g);
    @(posedge clk_i);
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);
    @(posedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
